// File: rtl/div_sched_if.sv
// Bundle between EXE, div_sched and the two divider IPs.
// Modport master is the div_sched side; slave is the EXE/IP side.
`timescale 1ns/1ps
interface div_sched_if #(
  parameter int DW = 32
);
  logic            req_valid;
  logic [3:0]      req_op;
  logic [DW-1:0]   req_src1;
  logic [DW-1:0]   req_src2;
  logic            req_ready;
  logic            resp_valid;
  logic [DW-1:0]   resp_data;
  logic            resp_ready;
  logic            flush;
  logic            s_tvalid;
  logic            s_tready_s;
  logic            s_tready_u;
  logic            s_sel_u;
  logic [DW-1:0]   s_divisor;
  logic [DW-1:0]   s_dividend;
  logic            dout_valid_s;
  logic            dout_valid_u;
  logic [2*DW-1:0] dout_data_s;
  logic [2*DW-1:0] dout_data_u;

  modport master (
    input  req_valid, req_op, req_src1, req_src2, resp_ready, flush,
           s_tready_s, s_tready_u, dout_valid_s, dout_valid_u, dout_data_s, dout_data_u,
    output req_ready, resp_valid, resp_data, s_tvalid, s_sel_u, s_divisor, s_dividend
  );

  modport slave (
    output req_valid, req_op, req_src1, req_src2, resp_ready, flush,
           s_tready_s, s_tready_u, dout_valid_s, dout_valid_u, dout_data_s, dout_data_u,
    input  req_ready, resp_valid, resp_data, s_tvalid, s_sel_u, s_divisor, s_dividend
  );
endinterface

// File: rtl/div_sched.sv
// Single-op sequencer in front of the signed/unsigned divider IPs, with flush draining.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero answered locally without the IP.
`timescale 1ns/1ps
module div_sched #(
  parameter int DW        = 32,
  parameter int QUIET_CYC = 40,
  parameter int QW        = 6
) (
  input  logic       clk,
  input  logic       resetn,
  div_sched_if.master bus
);

  typedef enum logic [2:0] {QUIET, IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

  state_t         state;
  logic [QW-1:0]  quiet_cnt;
  logic           is_mod;
  logic           op_onehot;
  logic           accept;
  logic           tready_sel;
  logic           dv_sel;
  logic           hs;
  logic [DW-1:0]  res_field;

  always_comb begin
    op_onehot  = (bus.req_op != '0) && ((bus.req_op & (bus.req_op - 4'd1)) == '0);
    accept     = bus.req_valid && !bus.flush && op_onehot;
    tready_sel = bus.s_sel_u ? bus.s_tready_u : bus.s_tready_s;
    dv_sel     = bus.s_sel_u ? bus.dout_valid_u : bus.dout_valid_s;
    hs         = bus.s_tvalid && tready_sel;
    if (bus.s_sel_u)
      res_field = is_mod ? bus.dout_data_u[DW-1:0] : bus.dout_data_u[2*DW-1:DW];
    else
      res_field = is_mod ? bus.dout_data_s[DW-1:0] : bus.dout_data_s[2*DW-1:DW];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= QUIET;
      quiet_cnt      <= '0;
      is_mod         <= 1'b0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.s_tvalid   <= 1'b0;
      bus.s_sel_u    <= 1'b0;
      bus.s_divisor  <= '0;
      bus.s_dividend <= '0;
    end else begin
      unique case (state)
        // IP has no reset: outputs are ignored until any pre-reset op has surely drained
        QUIET: begin
          if (quiet_cnt == QW'(QUIET_CYC - 1)) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
          end else begin
            quiet_cnt <= quiet_cnt + QW'(1);
          end
        end
        IDLE: begin
          if (accept) begin
            bus.req_ready <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
            if (bus.req_src2 == '0) begin
              bus.resp_data  <= (bus.req_op[2] | bus.req_op[0]) ? bus.req_src1 : '1;
              bus.resp_valid <= 1'b1;
              state          <= RESP;
            end else begin
`endif
              is_mod         <= bus.req_op[2] | bus.req_op[0];
              bus.s_sel_u    <= |bus.req_op[1:0];
              bus.s_divisor  <= bus.req_src2;
              bus.s_dividend <= bus.req_src1;
              bus.s_tvalid   <= 1'b1;
              state          <= ISSUE;
`ifdef DIV_ZERO_FAST_EN
            end
`endif
          end
        end
        ISSUE: begin
          if (hs) begin
            bus.s_tvalid <= 1'b0;
            state        <= bus.flush ? DRAIN : WAIT;
          end else if (bus.flush) begin
            bus.s_tvalid  <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        WAIT: begin
          if (bus.flush) begin
            if (dv_sel) begin
              bus.req_ready <= 1'b1;
              state         <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end else if (dv_sel) begin
            bus.resp_data  <= res_field;
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          if (bus.flush || bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end
        end
        DRAIN: begin
          if (dv_sel) begin
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= QUIET;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Randomized self-checking bench for div_sched; the bench also plays both divider IPs.
// Honours DIV_ZERO_FAST_EN for the divide-by-zero cases.
`timescale 1ns/1ps
module tb_div_sched;
  localparam int DW    = 32;
  localparam int QUIET = 40;
  localparam logic [3:0] OP_DIVW  = 4'b1000;
  localparam logic [3:0] OP_MODW  = 4'b0100;
  localparam logic [3:0] OP_DIVWU = 4'b0010;
  localparam logic [3:0] OP_MODWU = 4'b0001;

  logic clk = 1'b0;
  logic resetn;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  div_sched_if #(.DW(DW)) bif ();

  div_sched #(.DW(DW), .QUIET_CYC(QUIET), .QW(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bif)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Architectural result of a div/mod op; divide-by-zero follows the all-ones / dividend rule.
  function automatic logic [31:0] expect_val(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return (op == OP_MODW || op == OP_MODWU) ? a : 32'hFFFF_FFFF;
    case (op)
      OP_DIVW:  return 32'($signed(a) / $signed(b));
      OP_MODW:  return 32'($signed(a) % $signed(b));
      OP_DIVWU: return a / b;
      default:  return a % b;
    endcase
  endfunction

  // What the selected IP puts on its result bus: {quotient, remainder}.
  function automatic logic [63:0] ip_result(input logic u, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (u) return {a / b, a % b};
    return {32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b))};
  endfunction

  task automatic clear_inputs();
    bif.req_valid = 1'b0; bif.req_op = '0; bif.req_src1 = '0; bif.req_src2 = '0;
    bif.resp_ready = 1'b0; bif.flush = 1'b0;
    bif.s_tready_s = 1'b0; bif.s_tready_u = 1'b0;
    bif.dout_valid_s = 1'b0; bif.dout_valid_u = 1'b0;
    bif.dout_data_s = '0; bif.dout_data_u = '0;
  endtask

  task automatic set_tready(input logic u, input logic v);
    if (u) bif.s_tready_u = v; else bif.s_tready_s = v;
  endtask

  task automatic drive_dout(input logic u, input logic [63:0] d);
    if (u) begin bif.dout_valid_u = 1'b1; bif.dout_data_u = d; end
    else   begin bif.dout_valid_s = 1'b1; bif.dout_data_s = d; end
  endtask

  task automatic clear_dout();
    bif.dout_valid_s = 1'b0; bif.dout_valid_u = 1'b0;
  endtask

  // Random traffic from the IP that is not the target; it must be ignored.
  task automatic other_noise(input logic u);
    if (u) begin bif.dout_valid_s = 1'($urandom_range(0, 1)); bif.dout_data_s = {$urandom, $urandom}; end
    else   begin bif.dout_valid_u = 1'($urandom_range(0, 1)); bif.dout_data_u = {$urandom, $urandom}; end
  endtask

  task automatic reset_vals(input string pfx);
    check({pfx, "_req_ready"},  bif.req_ready, 0);
    check({pfx, "_resp_valid"}, bif.resp_valid, 0);
    check({pfx, "_s_tvalid"},   bif.s_tvalid, 0);
    check({pfx, "_s_sel_u"},    bif.s_sel_u, 0);
    check({pfx, "_resp_data"},  bif.resp_data, 0);
    check({pfx, "_s_divisor"},  bif.s_divisor, 0);
    check({pfx, "_s_dividend"}, bif.s_dividend, 0);
  endtask

  // Called right after reset release on a falling edge; request stays blocked for QUIET cycles.
  task automatic quiet_phase();
    for (int k = 1; k <= QUIET; k++) begin
      bif.req_valid = (k < QUIET - 1); bif.req_op = OP_DIVW;
      bif.req_src1 = $urandom; bif.req_src2 = 32'd3;
      if (k == 10) begin
        drive_dout(1'b0, {$urandom, $urandom});
        drive_dout(1'b1, {$urandom, $urandom});
      end else clear_dout();
      tick();
      check("quiet_req_ready", bif.req_ready, (k >= QUIET));
      check("quiet_resp_valid", bif.resp_valid, 0);
      check("quiet_s_tvalid", bif.s_tvalid, 0);
    end
    clear_inputs();
  endtask

  task automatic drain(input logic u, input int unsigned lat);
    bif.req_valid = 1'b1; bif.req_op = OP_DIVWU; bif.req_src1 = 32'd9; bif.req_src2 = 32'd3;
    repeat (lat) begin
      other_noise(u);
      bif.flush = 1'($urandom_range(0, 1));
      tick();
      check("drain_req_ready", bif.req_ready, 0);
      check("drain_resp_valid", bif.resp_valid, 0);
      check("drain_s_tvalid", bif.s_tvalid, 0);
    end
    bif.flush = 1'b0; clear_dout();
    drive_dout(u, {$urandom, $urandom});
    tick();
    clear_dout(); bif.req_valid = 1'b0;
    check("drain_done_req_ready", bif.req_ready, 1);
    check("drain_done_resp_valid", bif.resp_valid, 0);
    check("drain_no_issue", bif.s_tvalid, 0);
  endtask

  // fmode: 0 none, 1 flush in ISSUE, 2 flush with handshake, 3 flush in WAIT,
  //        4 flush with result, 5 flush in RESP
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int unsigned tr_dly, input int unsigned lat,
                       input int unsigned rr_dly, input int unsigned fmode);
    logic u;
    int unsigned t;
    u = op[1] | op[0];
    t = 0;
    while (bif.req_ready !== 1'b1 && t < 200) begin tick(); t++; end
    check("req_ready_wait", bif.req_ready, 1);
    bif.req_valid = 1'b1; bif.req_op = op; bif.req_src1 = a; bif.req_src2 = b;
    tick();
    bif.req_valid = 1'b0; bif.req_src1 = $urandom; bif.req_src2 = $urandom;
    check("issue_s_tvalid", bif.s_tvalid, 1);
    check("issue_s_sel_u", bif.s_sel_u, u);
    check("issue_s_divisor", bif.s_divisor, b);
    check("issue_s_dividend", bif.s_dividend, a);
    check("issue_req_ready", bif.req_ready, 0);
    if (fmode == 1) begin
      bif.flush = 1'b1; tick(); bif.flush = 1'b0;
      check("flush_issue_s_tvalid", bif.s_tvalid, 0);
      check("flush_issue_req_ready", bif.req_ready, 1);
      return;
    end
    set_tready(!u, 1'b1);
    repeat (tr_dly) begin
      tick();
      check("hold_s_tvalid", bif.s_tvalid, 1);
      check("hold_s_sel_u", bif.s_sel_u, u);
      check("hold_s_divisor", bif.s_divisor, b);
      check("hold_s_dividend", bif.s_dividend, a);
    end
    set_tready(!u, 1'b0); set_tready(u, 1'b1);
    if (fmode == 2) bif.flush = 1'b1;
    tick();
    set_tready(u, 1'b0); bif.flush = 1'b0;
    check("hs_s_tvalid_low", bif.s_tvalid, 0);
    if (fmode == 2) begin drain(u, lat); return; end
    repeat (lat) begin
      other_noise(u);
      tick();
      check("wait_resp_valid", bif.resp_valid, 0);
    end
    clear_dout();
    if (fmode == 3) begin
      bif.flush = 1'b1; tick(); bif.flush = 1'b0;
      check("flush_wait_req_ready", bif.req_ready, 0);
      drain(u, lat);
      return;
    end
    drive_dout(u, ip_result(u, a, b));
    if (fmode == 4) bif.flush = 1'b1;
    tick();
    clear_dout(); bif.flush = 1'b0;
    if (fmode == 4) begin
      check("flush_dout_resp_valid", bif.resp_valid, 0);
      check("flush_dout_req_ready", bif.req_ready, 1);
      return;
    end
    check("resp_valid", bif.resp_valid, 1);
    check("resp_data", bif.resp_data, exp);
    repeat (rr_dly) begin
      tick();
      check("resp_hold_valid", bif.resp_valid, 1);
      check("resp_hold_data", bif.resp_data, exp);
    end
    if (fmode == 5) begin bif.flush = 1'b1; bif.resp_ready = 1'($urandom_range(0, 1)); end
    else bif.resp_ready = 1'b1;
    tick();
    bif.flush = 1'b0; bif.resp_ready = 1'b0;
    check("resp_done_valid", bif.resp_valid, 0);
    check("resp_done_req_ready", bif.req_ready, 1);
  endtask

`ifdef DIV_ZERO_FAST_EN
  task automatic zero_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] exp);
    bif.req_valid = 1'b1; bif.req_op = op; bif.req_src1 = a; bif.req_src2 = '0;
    tick();
    bif.req_valid = 1'b0;
    check("zero_resp_valid", bif.resp_valid, 1);
    check("zero_resp_data", bif.resp_data, exp);
    check("zero_s_tvalid", bif.s_tvalid, 0);
    bif.resp_ready = 1'b1; tick(); bif.resp_ready = 1'b0;
    check("zero_done_valid", bif.resp_valid, 0);
    check("zero_done_s_tvalid", bif.s_tvalid, 0);
  endtask
`endif

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    int unsigned fm;
    logic [3:0]  bad_ops [4];

    clear_inputs();
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #1 reset_vals("rst");
    tick(); tick();
    resetn = 1'b1;
    quiet_phase();

    // Malformed op codes and flushed requests are refused while req_ready stays high
    bad_ops = '{4'b0000, 4'b0011, 4'b1100, 4'b1111};
    foreach (bad_ops[i]) begin
      bif.req_valid = 1'b1; bif.req_op = bad_ops[i]; bif.req_src1 = 32'd8; bif.req_src2 = 32'd2;
      tick();
      check("badop_s_tvalid", bif.s_tvalid, 0);
      check("badop_req_ready", bif.req_ready, 1);
    end
    bif.req_op = OP_DIVW; bif.flush = 1'b1;
    tick();
    bif.req_valid = 1'b0; bif.flush = 1'b0;
    check("flush_idle_s_tvalid", bif.s_tvalid, 0);
    check("flush_idle_req_ready", bif.req_ready, 1);

    do_op(OP_DIVW, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 0, 2, 0, 0);
    do_op(OP_MODWU, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 3, 1, 0, 0);
    do_op(OP_DIVW, $urandom, 32'd7, 32'd0, 0, 2, 0, 3);
    do_op(OP_DIVWU, 32'd9, 32'd3, 32'd3, 0, 1, 0, 0);
    do_op(OP_DIVW, 32'd50, 32'd5, 32'd10, 0, 1, 5, 5);
    do_op(OP_MODW, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1, 0, 1, 0);

`ifdef DIV_ZERO_FAST_EN
    zero_op(OP_DIVW, 32'd5, 32'hFFFF_FFFF);
    zero_op(OP_MODW, 32'd5, 32'd5);
`else
    do_op(OP_DIVW, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 2, 0, 0);
    do_op(OP_MODW, 32'd5, 32'd0, 32'd5, 0, 2, 0, 0);
`endif

    // Reset while the op sits in WAIT
    bif.req_valid = 1'b1; bif.req_op = OP_DIVWU; bif.req_src1 = 32'd77; bif.req_src2 = 32'd4;
    tick();
    bif.req_valid = 1'b0; bif.s_tready_u = 1'b1;
    tick();
    bif.s_tready_u = 1'b0;
    #2 resetn = 1'b0;
    #1 reset_vals("midrst");
    tick();
    resetn = 1'b1;
    quiet_phase();

    for (int i = 0; i < 60; i++) begin
      op = 4'b0001 << $urandom_range(0, 3);
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (b == 32'd0) b = 32'd1;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd7;
      fm = $urandom_range(0, 9);
      if (fm > 5) fm = 0;
      do_op(op, a, b, expect_val(op, a, b), $urandom_range(0, 3), $urandom_range(0, 5),
            $urandom_range(0, 3), fm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
